// File: rtl/mem_bus_if.sv
// Request/response handshake with the control path plus the Avalon-MM master bus.
// Request handshake: req_valid is held by the requester until req_ready; a request transfers at the clock edge where both are high.
interface mem_bus_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        misaligned;
  logic        bus_error;
  logic        stall;
  logic [31:0] address;
  logic        read;
  logic        write;
  logic        waitrequest;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic [31:0] readdata;

  modport master (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  waitrequest, readdata,
    output req_ready, rsp_valid, rsp_rdata, misaligned, bus_error, stall,
    output address, read, write, writedata, byteenable
  );

  modport slave (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output waitrequest, readdata,
    input  req_ready, rsp_valid, rsp_rdata, misaligned, bus_error, stall,
    input  address, read, write, writedata, byteenable
  );
endinterface

// File: rtl/mem_bus_sequencer.sv
// Sequences one CPU load/store/fetch at a time onto an Avalon-MM master bus,
// with lane steering, load extension, misalignment rejection and a waitrequest timeout.
module mem_bus_sequencer #(
  parameter int WAIT_TIMEOUT = 1024
) (
  input  logic       clk,
  input  logic       reset,
  mem_bus_if.master  bus,
  output logic [1:0] state_dbg
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUS = 2'd1, RESP = 2'd2} state_t;

  localparam int CW = (WAIT_TIMEOUT < 1) ? 1 : $clog2(WAIT_TIMEOUT + 1);
  localparam logic [CW-1:0] TIMEOUT_C  = CW'(WAIT_TIMEOUT);
  localparam logic          TIMEOUT_EN = (WAIT_TIMEOUT != 0);

  state_t      state;
  logic [CW-1:0] wait_cnt;
  logic        wr_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic [1:0]  lane_q;
  logic        req_misaligned;

  assign state_dbg = state;

  // Size 3 is reserved and behaves as a word access everywhere.
  assign req_misaligned = ((bus.req_size == 2'd1) && bus.req_addr[0]) ||
                          (bus.req_size[1] && (bus.req_addr[1:0] != 2'b00));

  function automatic logic [3:0] lane_enables(input logic [1:0] size, input logic [1:0] lane);
    logic [3:0] be;
    case (size)
      2'd0:    be = 4'b0001 << lane;
      2'd1:    be = lane[1] ? 4'b1100 : 4'b0011;
      default: be = 4'b1111;
    endcase
    return be;
  endfunction

  function automatic logic [31:0] replicate(input logic [1:0] size, input logic [31:0] d);
    logic [31:0] r;
    case (size)
      2'd0:    r = {4{d[7:0]}};
      2'd1:    r = {2{d[15:0]}};
      default: r = d;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] extract(input logic [31:0] d, input logic [1:0] size,
                                          input logic uns, input logic [1:0] lane);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    case (lane)
      2'd0:    b = d[7:0];
      2'd1:    b = d[15:8];
      2'd2:    b = d[23:16];
      default: b = d[31:24];
    endcase
    h = lane[1] ? d[31:16] : d[15:0];
    case (size)
      2'd0:    r = uns ? {24'b0, b} : {{24{b[7]}}, b};
      2'd1:    r = uns ? {16'b0, h} : {{16{h[15]}}, h};
      default: r = d;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wait_cnt       <= '0;
      wr_q           <= 1'b0;
      size_q         <= 2'd0;
      uns_q          <= 1'b0;
      lane_q         <= 2'd0;
      bus.req_ready  <= 1'b1;
      bus.rsp_valid  <= 1'b0;
      bus.rsp_rdata  <= '0;
      bus.misaligned <= 1'b0;
      bus.bus_error  <= 1'b0;
      bus.stall      <= 1'b0;
      bus.address    <= '0;
      bus.read       <= 1'b0;
      bus.write      <= 1'b0;
      bus.writedata  <= '0;
      bus.byteenable <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.req_valid) begin
            bus.req_ready <= 1'b0;
            wr_q          <= bus.req_write;
            size_q        <= bus.req_size;
            uns_q         <= bus.req_unsigned;
            lane_q        <= bus.req_addr[1:0];
            wait_cnt      <= '0;
            if (req_misaligned) begin
              bus.misaligned <= 1'b1;
              bus.rsp_valid  <= 1'b1;
              bus.rsp_rdata  <= '0;
              state          <= RESP;
            end else begin
              bus.address    <= {bus.req_addr[31:2], 2'b00};
              bus.byteenable <= lane_enables(bus.req_size, bus.req_addr[1:0]);
              bus.writedata  <= replicate(bus.req_size, bus.req_wdata);
              bus.read       <= !bus.req_write;
              bus.write      <= bus.req_write;
              bus.stall      <= 1'b1;
              state          <= BUS;
            end
          end
        end
        BUS: begin
          if (!bus.waitrequest) begin
            bus.read      <= 1'b0;
            bus.write     <= 1'b0;
            bus.stall     <= 1'b0;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= wr_q ? 32'h0 : extract(bus.readdata, size_q, uns_q, lane_q);
            state         <= RESP;
          end else if (TIMEOUT_EN && (wait_cnt == TIMEOUT_C - 1'b1)) begin
            // This stalled cycle is the last one tolerated: abandon the transfer.
            wait_cnt      <= TIMEOUT_C;
            bus.read      <= 1'b0;
            bus.write     <= 1'b0;
            bus.stall     <= 1'b0;
            bus.bus_error <= 1'b1;
            bus.rsp_valid <= 1'b1;
            bus.rsp_rdata <= '0;
            state         <= RESP;
          end else if (wait_cnt != '1) begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        RESP: begin
          bus.rsp_valid  <= 1'b0;
          bus.misaligned <= 1'b0;
          bus.bus_error  <= 1'b0;
          bus.req_ready  <= 1'b1;
          state          <= IDLE;
        end
        default: begin
          state         <= IDLE;
          bus.req_ready <= 1'b1;
        end
      endcase
    end
  end

endmodule
